// File: rtl/jk_pkg.sv
// Shared types for the jk_reg_bank flag register.
//
// Contents:
//   jk_mode_e  next-state semantics selector used by jk_reg_bank and jk_cell
//              (0=JK, 1=SR, 2=D, 3=T)
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE_JK = 2'd0,
        JK_MODE_SR = 2'd1,
        JK_MODE_D  = 2'd2,
        JK_MODE_T  = 2'd3
    } jk_mode_e;

endpackage

// File: rtl/jk_cell.sv
// One lane of the flag register: pure combinational next-state logic.
//
// Ports:
//   q         in   current lane state
//   j         in   J / S / D / T input
//   k         in   K / R input (ignored in D and T modes)
//   mode      in   next-state semantics (jk_mode_e)
//   q_next    out  lane value after the next enabled edge
//   conflict  out  SR mode with S=R=1 on this lane
module jk_cell
    import jk_pkg::*;
(
    input  logic     q,
    input  logic     j,
    input  logic     k,
    input  jk_mode_e mode,
    output logic     q_next,
    output logic     conflict
);

    // Next-state selection for the four flip-flop flavours.
    // In SR mode the S=R=1 case holds the lane and reports a conflict.
    always_comb begin
        q_next   = q;
        conflict = 1'b0;
        case (mode)
            JK_MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            JK_MODE_SR: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   conflict = 1'b1;
                    default: q_next = q;
                endcase
            end
            JK_MODE_D: q_next = j;
            JK_MODE_T: q_next = j ? ~q : q;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Parametrised bank of WIDTH flip-flops with run-time selectable JK/SR/D/T
// semantics, parallel load, global enable, change pulse and SR-conflict flag.
//
// Parameters:
//   WIDTH    number of lanes (>=1)
//   RST_VAL  value of q while reset is asserted
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   lane update enable (0 = hold)
//   mode        in   0=JK 1=SR 2=D 3=T for all lanes
//   j, k        in   per-lane inputs
//   load        in   parallel load strobe (beats en and mode)
//   load_val    in   value written on load
//   q           out  registered state
//   qn          out  ~q
//   chg         out  registered: q changed on the previous edge
//   sr_err      out  registered: SR mode with S=R=1 on some lane
//
// Optional feature, macro JK_STICKY_CHG_EN:
//   chg_clr     in   clears chg_sticky (a lane change on the same edge wins)
//   chg_sticky  out  per-lane accumulated change flags
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             chg,
    output logic             sr_err
`ifdef JK_STICKY_CHG_EN
    ,
    input  logic             chg_clr,
    output logic [WIDTH-1:0] chg_sticky
`endif
);

    jk_mode_e         mode_e;
    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] cell_conflict;
    logic [WIDTH-1:0] q_next;
    logic             err_next;

    assign mode_e = jk_mode_e'(mode);
    assign qn     = ~q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        jk_cell u_cell (
            .q        (q[i]),
            .j        (j[i]),
            .k        (k[i]),
            .mode     (mode_e),
            .q_next   (cell_next[i]),
            .conflict (cell_conflict[i])
        );
    end

    // Bank-wide priority: load, then enabled per-lane update, then hold.
    // A conflict only counts when the lane logic is actually in control.
    always_comb begin
        q_next   = q;
        err_next = 1'b0;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next   = cell_next;
            err_next = |cell_conflict;
        end
    end

    // State plus the two single-cycle status pulses, all on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RST_VAL;
            chg    <= 1'b0;
            sr_err <= 1'b0;
        end else begin
            q      <= q_next;
            chg    <= |(q_next ^ q);
            sr_err <= err_next;
        end
    end

`ifdef JK_STICKY_CHG_EN
    // Sticky change flags: a lane changing on this edge sets its bit even
    // when chg_clr is asserted at the same time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_sticky <= '0;
        end else begin
            chg_sticky <= (chg_sticky & ~{WIDTH{chg_clr}}) | (q_next ^ q);
        end
    end
`endif

`ifndef SYNTHESIS
    mode_known_a : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(mode))
        else $error("jk_reg_bank: mode is unknown");
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=8, RST_VAL=8'hA5).
// A word-level model built from the flip-flop characteristic equations is
// compared against the DUT on every falling edge; directed steps also pin
// hand-computed literal values.
module tb_jk_reg_bank;

    localparam int         W   = 8;
    localparam logic [7:0] RST = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic [7:0] qn;
    logic       chg;
    logic       sr_err;
`ifdef JK_STICKY_CHG_EN
    logic       chg_clr;
    logic [7:0] chg_sticky;
    logic [7:0] m_sticky = 8'h00;
`endif

    logic [7:0] m_q   = RST;
    logic       m_chg = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_nq;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    jk_reg_bank #(.WIDTH(W), .RST_VAL(RST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_val   (load_val),
        .q          (q),
        .qn         (qn),
        .chg        (chg),
        .sr_err     (sr_err)
`ifdef JK_STICKY_CHG_EN
        ,
        .chg_clr    (chg_clr),
        .chg_sticky (chg_sticky)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: characteristic equations applied to whole words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   = RST;
            m_chg = 1'b0;
            m_err = 1'b0;
`ifdef JK_STICKY_CHG_EN
            m_sticky = 8'h00;
`endif
        end else begin
            if (load)
                m_nq = load_val;
            else if (!en)
                m_nq = m_q;
            else if (mode == 2'd0)
                m_nq = (j & ~m_q) | (~k & m_q);
            else if (mode == 2'd1)
                m_nq = (j & ~k) | (m_q & ~(k & ~j));
            else if (mode == 2'd2)
                m_nq = j;
            else
                m_nq = m_q ^ j;
            m_err = (mode == 2'd1) && en && !load && ((j & k) != 8'h00);
            m_chg = (m_nq != m_q);
`ifdef JK_STICKY_CHG_EN
            m_sticky = (chg_clr ? 8'h00 : m_sticky) | (m_nq ^ m_q);
`endif
            m_q = m_nq;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_q", q, m_q);
            checkOutput("model_qn", qn, ~m_q);
            checkOutput("model_chg", {7'd0, chg}, {7'd0, m_chg});
            checkOutput("model_sr_err", {7'd0, sr_err}, {7'd0, m_err});
`ifdef JK_STICKY_CHG_EN
            checkOutput("model_sticky", chg_sticky, m_sticky);
`endif
        end
    end

    // Drive one set of inputs at a falling edge and return at the next one.
    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] jv,
                                 input logic [7:0] kv, input logic ld, input logic [7:0] lv);
        en       = e;
        mode     = m;
        j        = jv;
        k        = kv;
        load     = ld;
        load_val = lv;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'd0;
        j        = 8'h00;
        k        = 8'h00;
        load     = 1'b0;
        load_val = 8'h00;
`ifdef JK_STICKY_CHG_EN
        chg_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_q", q, 8'hA5);
        checkOutput("rst_qn", qn, 8'h5A);

        // JK toggle, toggle back, hold
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        checkOutput("load00_q", q, 8'h00);
        applyStimulus(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 8'h00);
        checkOutput("jk_tog1_q", q, 8'hFF);
        checkOutput("jk_tog1_chg", {7'd0, chg}, 8'h01);
        applyStimulus(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 8'h00);
        checkOutput("jk_tog2_q", q, 8'h00);
        applyStimulus(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00);
        checkOutput("jk_hold_q", q, 8'h00);
        checkOutput("jk_hold_chg", {7'd0, chg}, 8'h00);

        // SR conflict: lane 0 holds, lane 1 already set
        applyStimulus(1'b0, 2'd1, 8'h00, 8'h00, 1'b1, 8'h0F);
        applyStimulus(1'b1, 2'd1, 8'h03, 8'h01, 1'b0, 8'h00);
        checkOutput("sr_conf_q", q, 8'h0F);
        checkOutput("sr_conf_err", {7'd0, sr_err}, 8'h01);
        applyStimulus(1'b1, 2'd1, 8'h00, 8'h00, 1'b0, 8'h00);
        checkOutput("sr_clear_err", {7'd0, sr_err}, 8'h00);
        applyStimulus(1'b1, 2'd1, 8'h30, 8'h01, 1'b0, 8'h00);
        checkOutput("sr_setreset_q", q, 8'h3E);

        // Load beats enable and mode
        applyStimulus(1'b0, 2'd3, 8'hFF, 8'h00, 1'b1, 8'h3C);
        checkOutput("prio_load_q", q, 8'h3C);
        applyStimulus(1'b0, 2'd3, 8'hFF, 8'h00, 1'b0, 8'h00);
        checkOutput("prio_hold_q", q, 8'h3C);

        // D and T modes, then a load of the held value
        applyStimulus(1'b1, 2'd2, 8'h81, 8'h00, 1'b0, 8'h00);
        checkOutput("d_q", q, 8'h81);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h00, 1'b0, 8'h00);
        checkOutput("t1_q", q, 8'h80);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h00, 1'b0, 8'h00);
        checkOutput("t2_q", q, 8'h81);
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h81);
        checkOutput("load_same_chg", {7'd0, chg}, 8'h00);

        // Conflict inputs while disabled or loading raise no error
        applyStimulus(1'b0, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'h00);
        checkOutput("sr_dis_err", {7'd0, sr_err}, 8'h00);
        applyStimulus(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b1, 8'h55);
        checkOutput("sr_load_err", {7'd0, sr_err}, 8'h00);
        checkOutput("sr_load_q", q, 8'h55);
        applyStimulus(1'b1, 2'd1, 8'h01, 8'h01, 1'b0, 8'h00);
        checkOutput("sr_pre_rst_err", {7'd0, sr_err}, 8'h01);

        // Asynchronous reset in the middle of the high phase
        en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_q", q, 8'hA5);
        checkOutput("async_rst_err", {7'd0, sr_err}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'hFF, 8'h00, 1'b0, 8'h00);
        checkOutput("post_rst_q", q, 8'hFF);

`ifdef JK_STICKY_CHG_EN
        chg_clr = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00);
        chg_clr = 1'b0;
        applyStimulus(1'b1, 2'd0, 8'h04, 8'h04, 1'b0, 8'h00);
        checkOutput("sticky_set", chg_sticky, 8'h04);
        applyStimulus(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00);
        checkOutput("sticky_keep", chg_sticky, 8'h04);
        chg_clr = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'h00);
        chg_clr = 1'b0;
        checkOutput("sticky_clr_set", chg_sticky, 8'h01);
`endif

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
